pixel_fetch: RTL and testbench

- Per-pixel data path feeding the panel's RGB shift inputs.
- On each pixel-load request from the scan controller, it:
  - reads the top-half pixel (row N) and the bottom-half pixel (row N+16) from the RGB666 framebuffer RAM;
  - reduces each colour channel to one bit using the current brightness mask;
  - presents six registered colour bits (R1 G1 B1 R2 G2 B2) ahead of the next pixel clock.
- Sits between the scan controller (column/row/brightness source) and the panel pins.

---
 rtl/matrix_pkg.sv | 30 +++
 rtl/pixel_fetch_if.sv | 30 +++
 rtl/bitplane_select.sv | 19 +
 rtl/pixel_fetch.sv | 184 ++++++++++++++++++
 tb/tb_pixel_fetch.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED-matrix data path: panel geometry,
// pixel-fetch FSM states and the framebuffer address packing.
package matrix_pkg;

    localparam int PANEL_COLS      = 64;
    localparam int PANEL_ROWS_HALF = 16;
    localparam int CHAN_BITS       = 6;
    localparam int COL_W           = $clog2(PANEL_COLS);
    localparam int ROW_W           = $clog2(PANEL_ROWS_HALF);
    localparam int FB_ADDR_W       = 1 + ROW_W + COL_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_TOP = 3'd1,
        RD_BOT = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } fetch_state_t;

    // Bottom-half rows live in the upper half of the framebuffer, so row N+16
    // is reached by setting the MSB rather than adding to the row index.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(
        input logic             half,
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col
    );
        return {half, row, col};
    endfunction

endpackage

// File: rtl/pixel_fetch_if.sv
// Bundle of the scan-controller request, framebuffer read port and panel
// colour outputs of the pixel fetch block.
interface pixel_fetch_if #(
    parameter int COL_BITS  = matrix_pkg::COL_W,
    parameter int ROW_BITS  = matrix_pkg::ROW_W,
    parameter int CHAN_BITS = matrix_pkg::CHAN_BITS
);
    logic                         load_req;
    logic [COL_BITS-1:0]          column_address;
    logic [ROW_BITS-1:0]          row_address;
    logic [CHAN_BITS-1:0]         brightness_mask;
    logic                         ram_rd_en;
    logic [ROW_BITS+COL_BITS:0]   ram_addr;
    logic [3*CHAN_BITS-1:0]       ram_rd_data;
    logic [2:0]                   rgb_top;
    logic [2:0]                   rgb_bottom;
    logic                         pixel_valid;
    logic                         busy;
    logic                         overrun;

    modport master (
        output load_req, column_address, row_address, brightness_mask, ram_rd_data,
        input  ram_rd_en, ram_addr, rgb_top, rgb_bottom, pixel_valid, busy, overrun
    );

    modport slave (
        input  load_req, column_address, row_address, brightness_mask, ram_rd_data,
        output ram_rd_en, ram_addr, rgb_top, rgb_bottom, pixel_valid, busy, overrun
    );
endinterface

// File: rtl/bitplane_select.sv
// Reduces one {R,G,B} pixel to a single bit per channel: a channel lights
// when any of its bits selected by the brightness mask is set.
module bitplane_select #(
    parameter int CHAN_BITS = matrix_pkg::CHAN_BITS
) (
    input  logic [3*CHAN_BITS-1:0] pixel,
    input  logic [CHAN_BITS-1:0]   mask,
    output logic [2:0]             bits
);

    // Per-channel AND with the mask followed by OR reduction.
    always_comb begin
        bits    = 3'b000;
        bits[2] = |(pixel[3*CHAN_BITS-1 -: CHAN_BITS] & mask);
        bits[1] = |(pixel[2*CHAN_BITS-1 -: CHAN_BITS] & mask);
        bits[0] = |(pixel[CHAN_BITS-1   -: CHAN_BITS] & mask);
    end

endmodule

// File: rtl/pixel_fetch.sv
// Fetches the top and bottom half pixels for one panel column from the
// framebuffer and presents their current bit-plane as six registered bits.
module pixel_fetch #(
    parameter int RAM_LATENCY = 1,
    parameter int CHAN_BITS   = 6,
    parameter int COL_BITS    = 6,
    parameter int ROW_BITS    = 4
) (
    input logic          clk_in,
    input logic          reset,
    pixel_fetch_if.slave bus
);
    import matrix_pkg::*;

    localparam int ADDR_BITS = 1 + ROW_BITS + COL_BITS;

    fetch_state_t           state_r;
    fetch_state_t           state_s;
    logic [1:0]             wait_cnt_r;
    logic [1:0]             wait_cnt_s;
    logic                   accept_s;

    logic [COL_BITS-1:0]    col_r;
    logic [ROW_BITS-1:0]    row_r;
    logic [CHAN_BITS-1:0]   mask_r;

    logic                   rd_en_s;
    logic [ADDR_BITS-1:0]   addr_s;
    logic                   ram_rd_en_r;
    logic [ADDR_BITS-1:0]   ram_addr_r;

    logic [RAM_LATENCY-1:0] tag_vld_r;
    logic [RAM_LATENCY-1:0] tag_half_r;
    logic                   top_cap_s;
    logic                   bot_cap_s;
    logic [3*CHAN_BITS-1:0] top_pix_r;

    logic [2:0]             rgb_top_s;
    logic [2:0]             rgb_bottom_s;
    logic [2:0]             rgb_top_r;
    logic [2:0]             rgb_bottom_r;
    logic                   pixel_valid_r;
    logic                   busy_r;
    logic                   overrun_r;

    // State register and wait counter.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= 2'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Next-state logic; WAIT lasts RAM_LATENCY cycles so DONE follows the bottom data.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.load_req) begin
                    accept_s = 1'b1;
                    state_s  = RD_TOP;
                end else begin
                    state_s  = IDLE;
                end
            end
            RD_TOP: state_s = RD_BOT;
            RD_BOT: begin
                state_s    = WAIT;
                wait_cnt_s = 2'd0;
            end
            WAIT: begin
                if (wait_cnt_r == 2'(RAM_LATENCY - 1)) begin
                    state_s = DONE;
                end else begin
                    wait_cnt_s = wait_cnt_r + 2'd1;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Read strobe and address for the coming cycle; the address holds between reads.
    always_comb begin
        rd_en_s = 1'b0;
        addr_s  = ram_addr_r;
        case (state_s)
            RD_TOP: begin
                rd_en_s = 1'b1;
                addr_s  = fb_addr(1'b0, bus.row_address, bus.column_address);
            end
            RD_BOT: begin
                rd_en_s = 1'b1;
                addr_s  = fb_addr(1'b1, row_r, col_r);
            end
            default: begin
                rd_en_s = 1'b0;
                addr_s  = ram_addr_r;
            end
        endcase
    end

    // In-flight read tags: slot RAM_LATENCY-1 lines up with the returning data.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            tag_vld_r  <= '0;
            tag_half_r <= '0;
        end else begin
            tag_vld_r[0]  <= ram_rd_en_r;
            tag_half_r[0] <= ram_addr_r[ADDR_BITS-1];
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_vld_r[i]  <= tag_vld_r[i-1];
                tag_half_r[i] <= tag_half_r[i-1];
            end
        end
    end

    assign top_cap_s = tag_vld_r[RAM_LATENCY-1] & ~tag_half_r[RAM_LATENCY-1];
    assign bot_cap_s = tag_vld_r[RAM_LATENCY-1] &  tag_half_r[RAM_LATENCY-1];

    bitplane_select #(.CHAN_BITS(CHAN_BITS)) u_top_plane (
        .pixel (top_pix_r),
        .mask  (mask_r),
        .bits  (rgb_top_s)
    );

    // Bottom pixel is reduced straight off the RAM bus in the cycle it returns.
    bitplane_select #(.CHAN_BITS(CHAN_BITS)) u_bot_plane (
        .pixel (bus.ram_rd_data),
        .mask  (mask_r),
        .bits  (rgb_bottom_s)
    );

    // Request latch, data capture and all registered outputs.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            col_r         <= '0;
            row_r         <= '0;
            mask_r        <= '0;
            top_pix_r     <= '0;
            ram_rd_en_r   <= 1'b0;
            ram_addr_r    <= '0;
            rgb_top_r     <= 3'b000;
            rgb_bottom_r  <= 3'b000;
            pixel_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                col_r  <= bus.column_address;
                row_r  <= bus.row_address;
                mask_r <= bus.brightness_mask;
            end
            if (top_cap_s) begin
                top_pix_r <= bus.ram_rd_data;
            end
            if (bot_cap_s) begin
                rgb_top_r    <= rgb_top_s;
                rgb_bottom_r <= rgb_bottom_s;
            end
            if (bus.load_req && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            ram_rd_en_r   <= rd_en_s;
            ram_addr_r    <= addr_s;
            pixel_valid_r <= bot_cap_s;
            busy_r        <= (state_s != IDLE);
        end
    end

    assign bus.ram_rd_en   = ram_rd_en_r;
    assign bus.ram_addr    = ram_addr_r;
    assign bus.rgb_top     = rgb_top_r;
    assign bus.rgb_bottom  = rgb_bottom_r;
    assign bus.pixel_valid = pixel_valid_r;
    assign bus.busy        = busy_r;
    assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_pixel_fetch.sv
// Self-checking bench for pixel_fetch: one instance at RAM latency 1 and one
// at latency 3, each fed by a framebuffer model, checked against a reference.
module tb_pixel_fetch;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    logic [17:0] mem [0:2047];
    logic [17:0] ram1_q;
    logic [17:0] ram3_s0, ram3_s1, ram3_s2;

    pixel_fetch_if #(.COL_BITS(6), .ROW_BITS(4), .CHAN_BITS(6)) if1 ();
    pixel_fetch_if #(.COL_BITS(6), .ROW_BITS(4), .CHAN_BITS(6)) if3 ();

    pixel_fetch #(.RAM_LATENCY(1), .CHAN_BITS(6), .COL_BITS(6), .ROW_BITS(4)) dut1 (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (if1)
    );

    pixel_fetch #(.RAM_LATENCY(3), .CHAN_BITS(6), .COL_BITS(6), .ROW_BITS(4)) dut3 (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (if3)
    );

    always #5 clk_in = ~clk_in;

    // Framebuffer: data valid exactly LATENCY cycles after a read, garbage otherwise.
    always @(posedge clk_in) begin
        ram1_q  <= if1.ram_rd_en ? mem[if1.ram_addr] : 18'($urandom);
        ram3_s0 <= if3.ram_rd_en ? mem[if3.ram_addr] : 18'($urandom);
        ram3_s1 <= ram3_s0;
        ram3_s2 <= ram3_s1;
    end
    assign if1.ram_rd_data = ram1_q;
    assign if3.ram_rd_data = ram3_s2;

    function automatic logic [2:0] ref_bits(input logic [17:0] pix, input logic [5:0] mask);
        logic [2:0] r;
        int chan;
        r = 3'b000;
        for (int c = 0; c < 3; c++) begin
            chan = int'((pix >> (12 - 6 * c)) % 18'd64);
            r[2 - c] = ((chan & int'(mask)) != 0);
        end
        return r;
    endfunction

    function automatic int top_addr(input int row, input int col);
        return row * 64 + col;
    endfunction

    function automatic int bot_addr(input int row, input int col);
        return 1024 + (row + 16 - 16) * 64 + col;
    endfunction

    task automatic drive(input bit use3, input logic req, input logic [5:0] col,
                         input logic [3:0] row, input logic [5:0] mask);
        if1.load_req        = use3 ? 1'b0 : req;
        if3.load_req        = use3 ? req : 1'b0;
        if1.column_address  = col;
        if3.column_address  = col;
        if1.row_address     = row;
        if3.row_address     = row;
        if1.brightness_mask = mask;
        if3.brightness_mask = mask;
    endtask

    // Issues one request at cycle T and records what is seen in cycles T+1..T+15.
    task automatic run_fetch(input bit use3, input logic [5:0] col, input logic [3:0] row,
                             input logic [5:0] mask, input int extra_at,
                             output logic [10:0] a1, output logic [10:0] a2,
                             output logic [15:0] en_m, output logic [15:0] pv_m,
                             output logic [15:0] busy_m,
                             output logic [2:0] top, output logic [2:0] bot);
        a1 = '0; a2 = '0; en_m = '0; pv_m = '0; busy_m = '0; top = '0; bot = '0;
        @(negedge clk_in);
        drive(use3, 1'b1, col, row, mask);
        for (int n = 1; n < 16; n++) begin
            @(negedge clk_in);
            drive(use3, (n == extra_at), ~col, row, ~mask);
            en_m[n]   = use3 ? if3.ram_rd_en   : if1.ram_rd_en;
            pv_m[n]   = use3 ? if3.pixel_valid : if1.pixel_valid;
            busy_m[n] = use3 ? if3.busy        : if1.busy;
            if (n == 1) a1 = use3 ? if3.ram_addr : if1.ram_addr;
            if (n == 2) a2 = use3 ? if3.ram_addr : if1.ram_addr;
            if (pv_m[n]) begin
                top = use3 ? if3.rgb_top    : if1.rgb_top;
                bot = use3 ? if3.rgb_bottom : if1.rgb_bottom;
            end
        end
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        reset = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 4'd0, 6'd0);
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        obs = {if1.ram_rd_en, if1.ram_addr, if1.rgb_top, if1.rgb_bottom, if1.pixel_valid, if1.busy, if1.overrun};
        total++;
        if (obs !== 20'd0) begin bad++; $display("FAIL reset_lat1 got=%h want=0", obs); end
        obs = {if3.ram_rd_en, if3.ram_addr, if3.rgb_top, if3.rgb_bottom, if3.pixel_valid, if3.busy, if3.overrun};
        total++;
        if (obs !== 20'd0) begin bad++; $display("FAIL reset_lat3 got=%h want=0", obs); end
    endtask

    task automatic test_single();
        logic [10:0] a1, a2;
        logic [15:0] en_m, pv_m, busy_m;
        logic [2:0] top, bot;
        mem[11'h0C5] = {6'h3F, 6'h00, 6'h20};
        mem[11'h4C5] = {6'h00, 6'h21, 6'h1F};
        run_fetch(1'b0, 6'd5, 4'd3, 6'b100000, 0, a1, a2, en_m, pv_m, busy_m, top, bot);
        total++; if (a1 !== 11'h0C5) begin bad++; $display("FAIL single_addr_top got=%h want=0c5", a1); end
        total++; if (a2 !== 11'h4C5) begin bad++; $display("FAIL single_addr_bot got=%h want=4c5", a2); end
        total++; if (en_m !== 16'h0006) begin bad++; $display("FAIL single_rd_en got=%h want=0006", en_m); end
        total++; if (pv_m !== 16'h0010) begin bad++; $display("FAIL single_valid got=%h want=0010", pv_m); end
        total++; if (busy_m !== 16'h001E) begin bad++; $display("FAIL single_busy got=%h want=001e", busy_m); end
        total++; if (top !== 3'b101) begin bad++; $display("FAIL single_top got=%b want=101", top); end
        total++; if (bot !== 3'b010) begin bad++; $display("FAIL single_bot got=%b want=010", bot); end
        total++; if (if1.rgb_top !== 3'b101) begin bad++; $display("FAIL single_hold got=%b want=101", if1.rgb_top); end
    endtask

    task automatic test_mask_sweep();
        logic [10:0] a1, a2;
        logic [15:0] en_m, pv_m, busy_m;
        logic [2:0] top, bot;
        run_fetch(1'b0, 6'd5, 4'd3, 6'b000001, 0, a1, a2, en_m, pv_m, busy_m, top, bot);
        total++; if (top !== 3'b100) begin bad++; $display("FAIL mask1_top got=%b want=100", top); end
        total++; if (bot !== 3'b011) begin bad++; $display("FAIL mask1_bot got=%b want=011", bot); end
        run_fetch(1'b0, 6'd5, 4'd3, 6'b000000, 0, a1, a2, en_m, pv_m, busy_m, top, bot);
        total++; if (pv_m !== 16'h0010) begin bad++; $display("FAIL mask0_valid got=%h want=0010", pv_m); end
        total++; if ({top, bot} !== 6'b000000) begin bad++; $display("FAIL mask0_bits got=%b want=000000", {top, bot}); end
    endtask

    task automatic test_random();
        logic [10:0] a1, a2;
        logic [15:0] en_m, pv_m, busy_m, exp_pv, exp_busy;
        logic [2:0] top, bot;
        logic [5:0] col, mask;
        logic [3:0] row;
        bit use3;
        int lat;
        for (int i = 0; i < 16; i++) begin
            use3 = (i % 2) == 1;
            lat  = use3 ? 3 : 1;
            col  = 6'($urandom);
            row  = 4'($urandom);
            mask = 6'($urandom);
            run_fetch(use3, col, row, mask, 0, a1, a2, en_m, pv_m, busy_m, top, bot);
            exp_pv   = 16'(1 << (3 + lat));
            exp_busy = 16'((1 << (4 + lat)) - 2);
            total++; if (a1 !== 11'(top_addr(row, col))) begin bad++; $display("FAIL rand_addr_top i=%0d got=%h want=%h", i, a1, top_addr(row, col)); end
            total++; if (a2 !== 11'(bot_addr(row, col))) begin bad++; $display("FAIL rand_addr_bot i=%0d got=%h want=%h", i, a2, bot_addr(row, col)); end
            total++; if (pv_m !== exp_pv) begin bad++; $display("FAIL rand_valid i=%0d got=%h want=%h", i, pv_m, exp_pv); end
            total++; if (busy_m !== exp_busy) begin bad++; $display("FAIL rand_busy i=%0d got=%h want=%h", i, busy_m, exp_busy); end
            total++; if (top !== ref_bits(mem[top_addr(row, col)], mask)) begin bad++; $display("FAIL rand_top i=%0d got=%b want=%b", i, top, ref_bits(mem[top_addr(row, col)], mask)); end
            total++; if (bot !== ref_bits(mem[bot_addr(row, col)], mask)) begin bad++; $display("FAIL rand_bot i=%0d got=%b want=%b", i, bot, ref_bits(mem[bot_addr(row, col)], mask)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] masks [64];
        logic [3:0] rows [64];
        int pulses;
        int win_pv;
        logic [2:0] got_top, got_bot;
        pulses = 0;
        for (int k = 0; k < 64; k++) begin
            masks[k] = 6'($urandom);
            rows[k]  = 4'($urandom);
        end
        @(negedge clk_in);
        drive(1'b0, 1'b1, 6'd63, rows[0], masks[0]);
        for (int k = 0; k < 64; k++) begin
            win_pv = 0;
            got_top = 3'b000;
            got_bot = 3'b000;
            for (int n = 1; n <= 5; n++) begin
                @(negedge clk_in);
                if (if1.pixel_valid) begin
                    pulses++;
                    win_pv = win_pv + n;
                    got_top = if1.rgb_top;
                    got_bot = if1.rgb_bottom;
                end
                if (n == 5 && k < 63) drive(1'b0, 1'b1, 6'(62 - k), rows[k + 1], masks[k + 1]);
                else drive(1'b0, 1'b0, 6'd0, 4'd0, 6'd0);
            end
            total++; if (win_pv != 4) begin bad++; $display("FAIL b2b_valid_slot col=%0d got=%0d want=4", 63 - k, win_pv); end
            total++; if (got_top !== ref_bits(mem[top_addr(rows[k], 63 - k)], masks[k])) begin bad++; $display("FAIL b2b_top col=%0d got=%b want=%b", 63 - k, got_top, ref_bits(mem[top_addr(rows[k], 63 - k)], masks[k])); end
            total++; if (got_bot !== ref_bits(mem[bot_addr(rows[k], 63 - k)], masks[k])) begin bad++; $display("FAIL b2b_bot col=%0d got=%b want=%b", 63 - k, got_bot, ref_bits(mem[bot_addr(rows[k], 63 - k)], masks[k])); end
        end
        total++; if (pulses != 64) begin bad++; $display("FAIL b2b_pulses got=%0d want=64", pulses); end
        total++; if (if1.overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", if1.overrun); end
    endtask

    task automatic test_overrun();
        logic [10:0] a1, a2;
        logic [15:0] en_m, pv_m, busy_m;
        logic [2:0] top, bot;
        run_fetch(1'b0, 6'd17, 4'd9, 6'b010100, 2, a1, a2, en_m, pv_m, busy_m, top, bot);
        total++; if (pv_m !== 16'h0010) begin bad++; $display("FAIL ovr_valid got=%h want=0010", pv_m); end
        total++; if (a2 !== 11'(bot_addr(9, 17))) begin bad++; $display("FAIL ovr_addr_bot got=%h want=%h", a2, bot_addr(9, 17)); end
        total++; if (top !== ref_bits(mem[top_addr(9, 17)], 6'b010100)) begin bad++; $display("FAIL ovr_top got=%b want=%b", top, ref_bits(mem[top_addr(9, 17)], 6'b010100)); end
        total++; if (bot !== ref_bits(mem[bot_addr(9, 17)], 6'b010100)) begin bad++; $display("FAIL ovr_bot got=%b want=%b", bot, ref_bits(mem[bot_addr(9, 17)], 6'b010100)); end
        total++; if (if1.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", if1.overrun); end
        run_fetch(1'b0, 6'd2, 4'd1, 6'b000010, 0, a1, a2, en_m, pv_m, busy_m, top, bot);
        total++; if (if1.overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", if1.overrun); end
    endtask

    task automatic test_reset_mid_fetch();
        logic [19:0] obs;
        logic pv_seen, busy_seen;
        logic [10:0] a1, a2;
        logic [15:0] en_m, pv_m, busy_m;
        logic [2:0] top, bot;
        @(negedge clk_in);
        drive(1'b0, 1'b1, 6'd33, 4'd12, 6'b111111);
        @(negedge clk_in);
        drive(1'b0, 1'b0, 6'd0, 4'd0, 6'd0);
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        obs = {if1.ram_rd_en, if1.ram_addr, if1.rgb_top, if1.rgb_bottom, if1.pixel_valid, if1.busy, if1.overrun};
        total++; if (obs !== 20'd0) begin bad++; $display("FAIL midrst_zero got=%h want=0", obs); end
        pv_seen = 1'b0;
        busy_seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk_in);
            pv_seen   = pv_seen | if1.pixel_valid;
            busy_seen = busy_seen | if1.busy;
        end
        total++; if (pv_seen !== 1'b0) begin bad++; $display("FAIL midrst_no_valid got=%b want=0", pv_seen); end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL midrst_no_busy got=%b want=0", busy_seen); end
        run_fetch(1'b0, 6'd44, 4'd7, 6'b001000, 0, a1, a2, en_m, pv_m, busy_m, top, bot);
        total++; if (pv_m !== 16'h0010) begin bad++; $display("FAIL midrst_after_valid got=%h want=0010", pv_m); end
        total++; if ({top, bot} !== {ref_bits(mem[top_addr(7, 44)], 6'b001000), ref_bits(mem[bot_addr(7, 44)], 6'b001000)}) begin
            bad++; $display("FAIL midrst_after_data got=%b want=%b", {top, bot}, {ref_bits(mem[top_addr(7, 44)], 6'b001000), ref_bits(mem[bot_addr(7, 44)], 6'b001000)});
        end
    endtask

    task automatic test_latency3();
        logic [10:0] a1, a2;
        logic [15:0] en_m, pv_m, busy_m;
        logic [2:0] top, bot;
        mem[top_addr(9, 40)] = {6'h01, 6'h3E, 6'h04};
        mem[bot_addr(9, 40)] = {6'h10, 6'h04, 6'h00};
        run_fetch(1'b1, 6'd40, 4'd9, 6'b000101, 0, a1, a2, en_m, pv_m, busy_m, top, bot);
        total++; if (en_m !== 16'h0006) begin bad++; $display("FAIL lat3_rd_en got=%h want=0006", en_m); end
        total++; if (pv_m !== 16'h0040) begin bad++; $display("FAIL lat3_valid got=%h want=0040", pv_m); end
        total++; if (busy_m !== 16'h007E) begin bad++; $display("FAIL lat3_busy got=%h want=007e", busy_m); end
        total++; if (top !== 3'b111) begin bad++; $display("FAIL lat3_top got=%b want=111", top); end
        total++; if (bot !== 3'b010) begin bad++; $display("FAIL lat3_bot got=%b want=010", bot); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 18'($urandom);
        drive(1'b0, 1'b0, 6'd0, 4'd0, 6'd0);
        test_reset();
        test_single();
        test_mask_sweep();
        test_random();
        test_back_to_back();
        test_overrun();
        test_reset_mid_fetch();
        test_latency3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
